// File: rtl/clk_gen_pkg.sv
// Shared definitions for the multiphase clock generator.
//   - state_e      : sequencer states (idle, running, draining the current frame)
//   - NPhaseMin/NPhaseLimit : legal bounds for the number of gated phases
//   - clog2        : ceiling log2, used to size the phase-count/index fields
//   - clamp_phases : folds a requested phase count into [NPhaseMin, max_n]
package clk_gen_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDrain
    } state_e;

    localparam int unsigned NPhaseMin   = 2;
    localparam int unsigned NPhaseLimit = 16;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned res;
        res = 0;
        while ((32'd1 << res) < value) begin
            res++;
        end
        return res;
    endfunction

    function automatic int unsigned clamp_phases(input int unsigned num,
                                                 input int unsigned max_n);
        if (num < NPhaseMin) begin
            return NPhaseMin;
        end
        if (num > max_n) begin
            return max_n;
        end
        return num;
    endfunction

endpackage

// File: rtl/clk_gate_cell.sv
// Latch-based integrated clock gate.
//   clk_i  : free-running source clock
//   en_i   : functional enable, sampled while clk_i is low
//   te_i   : test enable, forces the gate open
//   gclk_o : gated clock, clk_i AND latched enable
// The latch is transparent only while clk_i is low, so an enable change during
// the high phase cannot shorten or split the pulse already in flight.
module clk_gate_cell (
    input  logic clk_i,
    input  logic en_i,
    input  logic te_i,
    output logic gclk_o
);

    logic en_lat;

    always_latch begin
        if (!clk_i) begin
            en_lat = en_i | te_i;
        end
    end

    assign gclk_o = clk_i & en_lat;

endmodule

// File: rtl/clk_gen_multiphase.sv
// Multiphase clock generator: rotates a one-hot enable over a programmable
// number of phases and gates the system clock once per phase per frame.
//   clock_sys_i   : system clock, all flops rising-edge
//   reset_i       : asynchronous active-high reset
//   enable_i      : run request; dropping it lets the current frame finish
//   cfg_num_i     : requested active phase count (clamped to 2..N_PHASE_MAX)
//   cfg_load_i    : strobe capturing cfg_num_i into the pending register
//   cfg_ack_o     : one-cycle pulse after a pending count is applied
//   phase_en_o    : registered one-hot phase enables, zero when idle
//   phase_idx_o   : registered current phase index
//   frame_start_o : registered, high together with phase_en_o[0]
//   clock_phase_o : clock_sys_i gated by phase_en_o[k]
module clk_gen_multiphase
    import clk_gen_pkg::*;
#(
    parameter int unsigned   N_PHASE_MAX  = 4,
    parameter int unsigned   RESET_PHASES = N_PHASE_MAX,
    localparam int unsigned  CNT_W        = clog2(N_PHASE_MAX + 1)
) (
    input  logic                   clock_sys_i,
    input  logic                   reset_i,
    input  logic                   enable_i,
    input  logic [CNT_W-1:0]       cfg_num_i,
    input  logic                   cfg_load_i,
    output logic                   cfg_ack_o,
    output logic [N_PHASE_MAX-1:0] phase_en_o,
    output logic [CNT_W-1:0]       phase_idx_o,
    output logic                   frame_start_o,
    output logic [N_PHASE_MAX-1:0] clock_phase_o
);

    state_e                 state_q, state_d;
    logic [CNT_W-1:0]       idx_q, idx_d;
    logic [CNT_W-1:0]       active_q, active_d;
    logic [CNT_W-1:0]       pend_q, pend_d;
    logic                   pend_vld_q, pend_vld_d;
    logic                   ack_q, ack_d;
    logic [N_PHASE_MAX-1:0] en_q, en_d;
    logic                   frame_q, frame_d;
    // Holds off the first start by one edge after reset release.
    logic                   arm_q;

    logic                   last;
    logic                   apply;
    logic                   cand_vld;
    logic [CNT_W-1:0]       cand_val;
    logic [CNT_W-1:0]       load_val;

    assign last     = (idx_q == active_q - CNT_W'(1));
    assign load_val = CNT_W'(clamp_phases(32'(cfg_num_i), N_PHASE_MAX));

    // State register
    always_ff @(posedge clock_sys_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and phase index
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        unique case (state_q)
            StIdle: begin
                if (enable_i && arm_q) begin
                    state_d = StRun;
                    idx_d   = '0;
                end
            end
            StRun, StDrain: begin
                // A drained frame ends on its last phase; re-enable resumes in place.
                if (enable_i) begin
                    state_d = StRun;
                end else if (last) begin
                    state_d = StIdle;
                end else begin
                    state_d = StDrain;
                end
                idx_d = last ? '0 : idx_q + CNT_W'(1);
            end
            default: begin
                state_d = StIdle;
                idx_d   = '0;
            end
        endcase
    end

    // Phase-count update: a load on the applying edge bypasses the pending register.
    always_comb begin
        cand_vld   = cfg_load_i | pend_vld_q;
        cand_val   = cfg_load_i ? load_val : pend_q;
        apply      = cand_vld && ((state_q == StIdle) || last);
        active_d   = apply ? cand_val : active_q;
        pend_d     = cand_val;
        pend_vld_d = cand_vld & ~apply;
        ack_d      = apply;
    end

    // Registered outputs derived from the next state
    always_comb begin
        en_d    = '0;
        if (state_d != StIdle) begin
            en_d = N_PHASE_MAX'(1) << idx_d;
        end
        frame_d = en_d[0];
    end

    always_ff @(posedge clock_sys_i or posedge reset_i) begin
        if (reset_i) begin
            idx_q      <= '0;
            active_q   <= CNT_W'(RESET_PHASES);
            pend_q     <= '0;
            pend_vld_q <= 1'b0;
            ack_q      <= 1'b0;
            en_q       <= '0;
            frame_q    <= 1'b0;
            arm_q      <= 1'b0;
        end else begin
            idx_q      <= idx_d;
            active_q   <= active_d;
            pend_q     <= pend_d;
            pend_vld_q <= pend_vld_d;
            ack_q      <= ack_d;
            en_q       <= en_d;
            frame_q    <= frame_d;
            arm_q      <= 1'b1;
        end
    end

    assign cfg_ack_o     = ack_q;
    assign phase_en_o    = en_q;
    assign phase_idx_o   = idx_q;
    assign frame_start_o = frame_q;

    for (genvar k = 0; k < N_PHASE_MAX; k++) begin : g_gate
        clk_gate_cell u_gate (
            .clk_i  (clock_sys_i),
            .en_i   (en_q[k]),
            .te_i   (1'b0),
            .gclk_o (clock_phase_o[k])
        );
    end

endmodule
